// File: rtl/psram_resp_pkg.sv
// Shared types and constants for the quad-SPI PSRAM responder.
package psram_resp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DUMMY  = 3'd3,
    RDATA  = 3'd4,
    WDATA  = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] DEF_READ_CMD  = 8'hEB;
  localparam logic [7:0] DEF_WRITE_CMD = 8'h38;
  localparam int         DEF_MEM_BYTES = 4096;

  function automatic int mem_idx_w(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int DEF_MEM_IDX_W = mem_idx_w(DEF_MEM_BYTES);

endpackage

// File: rtl/psram_sck_edge.sv
// Registers the link clock and data lanes; emits one-clk rise/fall pulses.
module psram_sck_edge (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic [3:0] d_i,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic [3:0] d_smp
);

  logic sck_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q    <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      d_smp    <= 4'h0;
    end else begin
      sck_q    <= sck;
      sck_rise <= sck & ~sck_q;
      sck_fall <= ~sck & sck_q;
      d_smp    <= d_i;
    end
  end

endmodule

// File: rtl/psram_qspi_responder.sv
// Device-side quad-SPI PSRAM responder backed by an internal byte array.
module psram_qspi_responder
  import psram_resp_pkg::*;
#(
  parameter int         ADDR_WIDTH  = 24,
  parameter int         MEM_BYTES   = DEF_MEM_BYTES,
  parameter int         WAIT_CYCLES = 6,
  parameter logic [7:0] READ_CMD    = DEF_READ_CMD,
  parameter logic [7:0] WRITE_CMD   = DEF_WRITE_CMD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] d_i,
  output logic [3:0] d_o,
  output logic [3:0] d_oe,
  output logic       err
);

  localparam int IDX_W = mem_idx_w(MEM_BYTES);

  state_t           state;
  logic [15:0]      cnt;
  logic [6:0]       cmd_sr;
  logic [IDX_W-1:0] addr;
  logic             is_read;
  logic             half;
  logic [3:0]       wr_hi;
  logic             ce_q;
  logic             sck_rise;
  logic             sck_fall;
  logic [3:0]       d_smp;
  logic [7:0]       opcode;
  logic [7:0]       rd_byte;
  logic             mem_we;
  logic [7:0]       mem [MEM_BYTES];

  psram_sck_edge u_edge (
    .clk      (clk),
    .rst      (rst),
    .sck      (sck),
    .d_i      (d_i),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .d_smp    (d_smp)
  );

  assign opcode  = {cmd_sr, d_smp[0]};
  assign rd_byte = mem[addr];
  assign mem_we  = !rst && !ce_n && (state == WDATA) && sck_rise && half;

  // Backing store: no reset so it maps onto a plain single-port RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= {wr_hi, d_smp};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 16'd0;
      cmd_sr  <= 7'd0;
      addr    <= '0;
      is_read <= 1'b0;
      half    <= 1'b0;
      wr_hi   <= 4'h0;
      ce_q    <= 1'b0;  // forces a fresh high-to-low ce_n after reset
      d_o     <= 4'h0;
      d_oe    <= 4'h0;
      err     <= 1'b0;
    end else begin
      ce_q <= ce_n;
      err  <= 1'b0;
      if (ce_n) begin
        // ce_n high overrides any coincident sck edge and drops partial bytes
        state <= IDLE;
        half  <= 1'b0;
        d_o   <= 4'h0;
        d_oe  <= 4'h0;
      end else begin
        case (state)
          IDLE: begin
            if (ce_q) begin
              state <= CMD;
              cnt   <= 16'd0;
              half  <= 1'b0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              cmd_sr <= opcode[6:0];
              cnt    <= cnt + 16'd1;
              if (cnt == 16'd7) begin
                cnt <= 16'd0;
                if (opcode == READ_CMD) begin
                  is_read <= 1'b1;
                  state   <= ADDR;
                end else if (opcode == WRITE_CMD) begin
                  is_read <= 1'b0;
                  state   <= ADDR;
                end else begin
                  err   <= 1'b1;
                  state <= IGNORE;
                end
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              // keeping only the low index bits makes addressing modulo MEM_BYTES
              addr <= IDX_W'({addr, d_smp});
              cnt  <= cnt + 16'd1;
              if (cnt == 16'(ADDR_WIDTH / 4 - 1)) begin
                cnt <= 16'd0;
                if (!is_read) begin
                  state <= WDATA;
                end else if (WAIT_CYCLES == 0) begin
                  state <= RDATA;
                end else begin
                  state <= DUMMY;
                end
              end
            end
          end
          DUMMY: begin
            if (sck_rise) begin
              cnt <= cnt + 16'd1;
              if (cnt == 16'(WAIT_CYCLES - 1)) begin
                cnt   <= 16'd0;
                state <= RDATA;
              end
            end
          end
          RDATA: begin
            if (sck_fall) begin
              d_oe <= 4'hF;
              if (!half) begin
                d_o  <= rd_byte[7:4];
                half <= 1'b1;
              end else begin
                d_o  <= rd_byte[3:0];
                half <= 1'b0;
                addr <= addr + 1'b1;
              end
            end
          end
          WDATA: begin
            if (sck_rise) begin
              if (!half) begin
                wr_hi <= d_smp;
                half  <= 1'b1;
              end else begin
                half <= 1'b0;
                addr <= addr + 1'b1;
              end
            end
          end
          IGNORE: begin
            state <= IGNORE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
// Directed self-checking bench for psram_qspi_responder.
module tb_psram_qspi_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       ce;
  logic       sel0;
  logic [3:0] d_i;
  logic       ce_a, ce_b;
  logic [3:0] d_o_a, d_oe_a, d_o_b, d_oe_b;
  logic       err_a, err_b;

  int         errors = 0;
  int         checks = 0;
  int         err_cnt = 0;
  logic [3:0] oe_or = 4'h0;

  always #5 clk = ~clk;

  assign ce_a = sel0 ? 1'b1 : ce;
  assign ce_b = sel0 ? ce : 1'b1;

  psram_qspi_responder #(.WAIT_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_a), .d_i(d_i),
    .d_o(d_o_a), .d_oe(d_oe_a), .err(err_a)
  );

  psram_qspi_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_b), .d_i(d_i),
    .d_o(d_o_b), .d_oe(d_oe_b), .err(err_b)
  );

  always @(negedge clk) begin
    if (err_a) err_cnt = err_cnt + 1;
    oe_or = oe_or | d_oe_a;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [3:0] din, output logic [3:0] dout, output logic [3:0] oe);
    sck = 1'b0;
    d_i = din;
    repeat (3) @(posedge clk);
    #1;
    dout = sel0 ? d_o_b : d_o_a;
    oe   = sel0 ? d_oe_b : d_oe_a;
    sck  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic begin_txn();
    sck = 1'b0;
    ce  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic end_txn();
    ce  = 1'b1;
    sck = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] n, o;
    for (int i = 7; i >= 0; i--) tick({3'b000, b[i]}, n, o);
  endtask

  task automatic send_addr(input logic [23:0] a);
    logic [3:0] n, o;
    for (int i = 5; i >= 0; i--) tick(a[4*i +: 4], n, o);
  endtask

  task automatic write2(input logic [23:0] a, input logic [15:0] data);
    logic [3:0] n, o;
    begin_txn();
    send_byte(8'h38);
    send_addr(a);
    for (int i = 3; i >= 0; i--) tick(data[4*i +: 4], n, o);
    end_txn();
  endtask

  // Reads n nibbles; oe_and is the AND of d_oe over data ticks, oe_dum the OR over dummy ticks.
  task automatic read_nibs(input logic [23:0] a, input int n, output logic [15:0] data,
                           output logic [3:0] oe_and, output logic [3:0] oe_dum);
    logic [3:0] nb, o;
    data   = 16'h0;
    oe_and = 4'hF;
    oe_dum = 4'h0;
    begin_txn();
    send_byte(8'hEB);
    send_addr(a);
    if (!sel0) begin
      for (int i = 0; i < 6; i++) begin
        tick(4'h0, nb, o);
        oe_dum = oe_dum | o;
      end
    end
    for (int i = 0; i < n; i++) begin
      tick(4'h0, nb, o);
      data   = {data[11:0], nb};
      oe_and = oe_and & o;
    end
    end_txn();
  endtask

  initial begin
    logic [15:0] rd;
    logic [3:0]  oa, od, nb, o;

    rst  = 1'b1;
    ce   = 1'b1;
    sck  = 1'b0;
    sel0 = 1'b0;
    d_i  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_d_o", {28'h0, d_o_a}, 32'h0);
    check("reset_d_oe", {28'h0, d_oe_a}, 32'h0);
    check("reset_err", {31'h0, err_a}, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // basic write then read
    write2(24'h000010, 16'hA53C);
    read_nibs(24'h000010, 4, rd, oa, od);
    check("rd_0x10", {16'h0, rd}, 32'h0000A53C);
    check("rd_oe_data", {28'h0, oa}, 32'hF);
    check("rd_oe_dummy", {28'h0, od}, 32'h0);
    check("oe_after_ce", {28'h0, d_oe_a}, 32'h0);

    // wrap past MEM_BYTES-1
    write2(24'h000FFF, 16'h1122);
    read_nibs(24'h000000, 2, rd, oa, od);
    check("wrap_rd_0", {16'h0, rd}, 32'h22);
    read_nibs(24'h000FFF, 2, rd, oa, od);
    check("wrap_rd_fff", {16'h0, rd}, 32'h11);

    // unknown opcode
    err_cnt = 0;
    oe_or   = 4'h0;
    begin_txn();
    send_byte(8'h9F);
    send_addr(24'h000010);
    for (int i = 0; i < 14; i++) tick(4'h0, nb, o);
    end_txn();
    check("bad_op_err_pulses", err_cnt, 32'd1);
    check("bad_op_oe", {28'h0, oe_or}, 32'h0);
    read_nibs(24'h000010, 4, rd, oa, od);
    check("bad_op_mem", {16'h0, rd}, 32'h0000A53C);

    // truncated write: third nibble discarded
    write2(24'h000020, 16'h0099);
    begin_txn();
    send_byte(8'h38);
    send_addr(24'h000020);
    tick(4'h7, nb, o);
    tick(4'hE, nb, o);
    tick(4'h5, nb, o);
    end_txn();
    read_nibs(24'h000020, 4, rd, oa, od);
    check("partial_wr", {16'h0, rd}, 32'h00007E99);

    // reset during RDATA
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000010);
    for (int i = 0; i < 6; i++) tick(4'h0, nb, o);
    tick(4'h0, nb, o);
    check("pre_rst_nib", {28'h0, nb}, 32'hA);
    check("pre_rst_oe", {28'h0, o}, 32'hF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_oe", {28'h0, d_oe_a}, 32'h0);
    check("rst_d_o", {28'h0, d_o_a}, 32'h0);
    rst = 1'b0;
    oe_or = 4'h0;
    for (int i = 0; i < 3; i++) tick(4'h0, nb, o);
    check("ce_low_no_start", {28'h0, oe_or}, 32'h0);
    end_txn();
    read_nibs(24'h000010, 2, rd, oa, od);
    check("post_rst_rd", {16'h0, rd}, 32'hA5);

    // zero wait cycles on the second instance
    sel0 = 1'b1;
    write2(24'h000040, 16'hB7D2);
    begin_txn();
    send_byte(8'hEB);
    send_addr(24'h000040);
    tick(4'h0, nb, o);
    check("w0_first_nib", {28'h0, nb}, 32'hB);
    check("w0_first_oe", {28'h0, o}, 32'hF);
    tick(4'h0, nb, o);
    check("w0_second_nib", {28'h0, nb}, 32'h7);
    end_txn();
    sel0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
